// File: rtl/layer1_pkg.sv
// Shared constants and types for the layer1 buffer controller.
// Pure declarations: no latency, no backpressure.
package layer1_pkg;
    localparam int L1_DEPTH      = 912;
    localparam int L1_AW         = 10;
    localparam int L1_DW         = 128;
    localparam int RD_FIFO_DEPTH = 3;

    typedef enum logic [1:0] {IDLE, FILL, DONE} l1_state_e;
endpackage

// File: rtl/layer1_buffer_ctrl_if.sv
// Write stream, read request and read response channels of the layer1 buffer.
// Valid/ready on every channel; the controller side uses the slave modport.
interface layer1_buffer_ctrl_if;
    import layer1_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [L1_DW-1:0] wr_data;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [L1_AW-1:0] rd_req_addr;
    logic             rd_data_valid;
    logic             rd_data_ready;
    logic [L1_DW-1:0] rd_data;
    logic             rd_data_err;

    modport master (
        output wr_valid, wr_data, rd_req_valid, rd_req_addr, rd_data_ready,
        input  wr_ready, rd_req_ready, rd_data_valid, rd_data, rd_data_err
    );

    modport slave (
        input  wr_valid, wr_data, rd_req_valid, rd_req_addr, rd_data_ready,
        output wr_ready, rd_req_ready, rd_data_valid, rd_data, rd_data_err
    );
endinterface

// File: rtl/l1_rd_resp_fifo.sv
// Small response FIFO with occupancy count; head visible combinationally, zero when empty.
// Push is dropped only when full without a same-cycle pop; push+pop when full is allowed.
module l1_rd_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 129,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic          vld,
    output logic [W-1:0]  out_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end

    assign vld     = (cnt != '0);
    assign out_dat = vld ? mem[rptr] : '0;
    assign count   = cnt;
endmodule

// File: rtl/layer1_buffer_ctrl.sv
// Fill/read arbiter for the layer1 dual-port SRAM: sequential writes on A, gated random reads on B.
// Reads return 2 cycles after acceptance; requests stall on unwritten words or when response credits run out.
module layer1_buffer_ctrl
    import layer1_pkg::*;
(
    input  logic                  CK,
    input  logic                  RSTN,
    input  logic                  layer_start,
    layer1_buffer_ctrl_if.slave   bus,
    output logic                  layer_done,
    output logic [L1_AW-1:0]      wr_count,
    output logic [L1_AW-1:0]      l1_A,
    output logic [L1_AW-1:0]      l1_B,
    output logic                  l1_WEAN,
    output logic                  l1_WEBN,
    output logic                  l1_OEA,
    output logic                  l1_OEB,
    output logic [L1_DW-1:0]      l1_DIA,
    output logic [L1_DW-1:0]      l1_DIB,
    input  logic [L1_DW-1:0]      l1_DOB
);
    localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

    l1_state_e        state, state_nxt;
    logic             wr_fire, last_wr;
    logic             rd_in_range, addr_ok, credit_ok, rd_fire, rd_issue;
    logic             s1_vld, s1_err;
    logic [L1_AW-1:0] b_hold;
    logic [CW-1:0]    fifo_cnt;
    logic [CW:0]      occ;
    logic             fifo_pop;
    logic [L1_DW:0]   fifo_out;

    assign bus.wr_ready = (state == FILL);
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign last_wr      = wr_fire && (wr_count == L1_AW'(L1_DEPTH - 1));

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (layer_start) state_nxt = FILL;
            FILL:    if (!layer_start && last_wr) state_nxt = DONE;
            DONE:    if (layer_start) state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    // A restart wins over a coincident write so the new fill always begins at word 0.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN)            wr_count <= '0;
        else if (layer_start) wr_count <= '0;
        else if (wr_fire)     wr_count <= wr_count + 1'b1;
    end

    assign layer_done = (state == DONE);

    assign l1_A    = wr_fire ? wr_count : '0;
    assign l1_WEAN = !wr_fire;
    assign l1_DIA  = wr_fire ? bus.wr_data : '0;
    assign l1_OEA  = 1'b0;
    assign l1_WEBN = 1'b1;
    assign l1_DIB  = '0;

    // Credits count FIFO entries plus the read sitting in the SRAM stage, net of this cycle's pop.
    assign fifo_pop  = bus.rd_data_valid && bus.rd_data_ready;
    assign occ       = {1'b0, fifo_cnt} + (CW + 1)'(s1_vld) - (CW + 1)'(fifo_pop);
    assign credit_ok = occ < (CW + 1)'(RD_FIFO_DEPTH);

    assign rd_in_range      = bus.rd_req_addr < L1_AW'(L1_DEPTH);
    assign addr_ok          = !rd_in_range || (bus.rd_req_addr < wr_count) || (state == DONE);
    assign bus.rd_req_ready = (state != IDLE) && credit_ok && addr_ok;
    assign rd_fire          = bus.rd_req_valid && bus.rd_req_ready;
    assign rd_issue         = rd_fire && rd_in_range;

    assign l1_OEB = rd_issue;
    assign l1_B   = rd_issue ? bus.rd_req_addr : b_hold;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            b_hold <= '0;
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            b_hold <= l1_B;
            s1_vld <= rd_fire;
            s1_err <= rd_fire && !rd_in_range;
        end
    end

    l1_rd_resp_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .W     (L1_DW + 1),
        .CW    (CW)
    ) u_resp_fifo (
        .clk      (CK),
        .rst_n    (RSTN),
        .push     (s1_vld),
        .push_dat ({s1_err, s1_err ? {L1_DW{1'b0}} : l1_DOB}),
        .pop      (fifo_pop),
        .vld      (bus.rd_data_valid),
        .out_dat  (fifo_out),
        .count    (fifo_cnt)
    );

    assign bus.rd_data_err = fifo_out[L1_DW];
    assign bus.rd_data     = fifo_out[L1_DW-1:0];
endmodule

// File: doc/layer1_buffer_ctrl.md
# layer1_buffer_ctrl

Access controller that sits in front of the layer1 dual-port SRAM wrapper (912 × 128-bit) and drives both of its ports. The conv-output stream fills the buffer sequentially through port A (write-only). The next layer's fetch unit issues random-address reads through port B (read-only) over a valid/ready request channel and receives data over a valid/ready response channel. The block tracks fill progress, blocks reads of not-yet-written words, and raises `layer_done` when the layer is complete.

## Interface
- `L1_DEPTH`, 912: number of words in the buffer.
- `L1_AW`, 10: address width.
- `L1_DW`, 128: data width.
- `RD_FIFO_DEPTH`, 3: depth of the response buffer.

Ports:
- `CK` in 1: clock. One clock domain; also drives the SRAM `CK`.
- `RSTN` in 1: reset, asynchronous, active-low.
- `layer_start` in 1: one-cycle pulse that starts or restarts a fill.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in 128: sequential write stream.
- `rd_req_valid` in 1, `rd_req_ready` out 1, `rd_req_addr` in 10: read request channel.
- `rd_data_valid` out 1, `rd_data_ready` in 1, `rd_data` out 128, `rd_data_err` out 1: read response channel.
- `layer_done` out 1: level signal, high while all `L1_DEPTH` words are written.
- `wr_count` out 10: number of words written in the current fill.
- SRAM side: `l1_A` out 10, `l1_B` out 10, `l1_WEAN` out 1, `l1_WEBN` out 1, `l1_OEA` out 1, `l1_OEB` out 1, `l1_DIA` out 128, `l1_DIB` out 128, `l1_DOB` in 128.

## Operation
- FSM states:
  - IDLE → FILL on `layer_start`.
  - FILL → DONE when the write of address `L1_DEPTH-1` is accepted.
  - DONE → FILL on `layer_start`.
  - `layer_start` during FILL restarts the fill: `wr_count` ← 0 and the state stays FILL.
- Write path:
  - `wr_ready` = (state == FILL).
  - On a write handshake, the same cycle drives `l1_A` = `wr_count`, `l1_WEAN` = 0, `l1_DIA` = `wr_data`; `wr_count` increments at the clock edge.
  - With no handshake: `l1_WEAN` = 1, `l1_DIA` = 0.
- Port usage is fixed: `l1_OEA` = 0, `l1_WEBN` = 1, `l1_DIB` = 0 at all times.
- Read admission:
  - `rd_req_ready` = (state ≠ IDLE) AND credit_ok AND (`rd_req_addr` ≥ `L1_DEPTH` OR `rd_req_addr` < `wr_count` OR state == DONE).
  - credit_ok = (fifo_count + inflight − pop) < `RD_FIFO_DEPTH`.
- Read execution:
  - On an accepted in-range read: `l1_B` = `rd_req_addr`, `l1_OEB` = 1 in the same cycle.
  - Otherwise `l1_OEB` = 0 and `l1_B` holds its last value.
  - `l1_DOB` is captured on the following edge into the response FIFO.
- Out-of-range read (address ≥ 912): accepted without touching the SRAM; returns `rd_data` = 0 with `rd_data_err` = 1.
- Address conflicts: reads are only issued below `wr_count` and writes only at `wr_count`, so `l1_A` ≠ `l1_B` whenever both ports are active. The wrapper's address-collision remap therefore never fires.
- `layer_start` does not flush in-flight or buffered reads; they complete normally.

## Timing
- Write: accepted in cycle N; SRAM written at edge N+1; the word becomes readable (visible in `wr_count`) from cycle N+1.
- Read latency:
  - Request accepted in cycle N.
  - SRAM output valid in N+1.
  - FIFO entry, and `rd_data_valid` if the FIFO was empty, in N+2.
- Throughput: sustained one read per cycle when `rd_data_ready` = 1.
- Response ordering is strict FIFO. A response is held stable while `rd_data_valid` = 1 and `rd_data_ready` = 0.
- `layer_done` rises in the cycle after the final write handshake. It falls in the cycle after a `layer_start`.
- Reset values:
  - state IDLE; `wr_count` 0; FIFO empty, inflight 0.
  - `wr_ready`, `rd_req_ready`, `rd_data_valid`, `rd_data_err`, `layer_done` all 0; `rd_data` 0.
  - `l1_WEAN` = `l1_WEBN` = 1; `l1_OEA` = `l1_OEB` = 0; `l1_A` = `l1_B` = 0; `l1_DIA` = `l1_DIB` = 0.
- Asserting reset mid-operation discards all buffered and in-flight responses immediately.

## Structure
- Package `layer1_pkg`: `L1_DEPTH`, `L1_AW`, `L1_DW`, and `typedef enum {IDLE, FILL, DONE} l1_state_e`.
- Sub-module `l1_rd_resp_fifo`: `RD_FIFO_DEPTH`-entry FIFO of {err, data} with count output. Push and pop in the same cycle are allowed when it is full.
- The FSM, write counter, credit logic and SRAM port drive stay in the top module.

## Test plan
- Reset, then idle: all outputs hold their reset values; `wr_ready` = 0; a `rd_req_valid` to address 0 is not accepted.
- `layer_start`, then 912 back-to-back writes of data = address: `l1_WEAN` is low for 912 consecutive cycles with `l1_A` counting 0..911; `layer_done` = 1 in the next cycle; `wr_ready` = 0 afterwards.
- Read during fill with `wr_count` = 5:
  - addr 4 is accepted and returns 4 two cycles later.
  - addr 5 stalls until the 6th write is accepted.
- DONE state, `rd_data_ready` held low, 3 reads issued: exactly 3 are accepted, the 4th is stalled. Releasing `rd_data_ready` returns the data in order.
- Read of addr 1000: accepted with `l1_OEB` = 0; response `rd_data` = 0 with `rd_data_err` = 1.
- `layer_start` at `wr_count` = 400 with 2 reads in flight: both reads return old data; `wr_count` = 0; the next write targets `l1_A` = 0. Repeat with `RSTN` low mid-read: all valids drop immediately.
